// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // All-ones anode pattern in the low n bits (n = 1..8).
  function automatic logic [7:0] an_off(input int n);
    return 8'((9'd1 << n) - 9'd1);
  endfunction

  // Pick nibble idx out of a packed nibble vector (up to 8 nibbles).
  function automatic logic [3:0] nib_sel(input logic [31:0] nibs, input logic [2:0] idx);
    return nibs[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_7seg.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Pure lookup; shared by all digits through the scan mux.
  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode display scanner with frame-aligned double buffering,
// per-digit enable, decimal points, leading-zero blanking and an anti-ghost gap.
// Slot phases (BLANK then DRIVE) come straight from the slot counter.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  input  logic                    lz_supp_i,
  input  logic                    load_i,
  output logic                    load_ack_o,
  output logic                    frame_tick_o,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]    AN_OFF8   = an_off(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_OFF8[NUM_DIGITS-1:0];

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_ctrl: NUM_DIGITS must be 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("seg7_scan_ctrl: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES > REFRESH_DIV - 1) begin : g_bad_blank
    $error("seg7_scan_ctrl: BLANK_CYCLES must be 0..REFRESH_DIV-1");
  end

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   stage_nib_q, stage_nib_d, shadow_nib_q, shadow_nib_d;
  logic [NUM_DIGITS-1:0]     stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
  logic                      pending_q, pending_d;
  logic [7:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      ack_q, tick_q;

  logic                      slot_end, boundary, in_blank, visible, zeros_above;
  logic [NUM_DIGITS-1:0]     supp, an_sel;
  logic [3:0]                cur_nib;
  logic [6:0]                dec;

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);
  assign in_blank = (BLANK_CYCLES > 0) && (cnt_q < BLANK_END);

  // Slot counter and digit index advance.
  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Staging captures every LOAD; the shadow only changes at a frame boundary,
  // using the staging value held before this cycle's LOAD (if any).
  always_comb begin
    stage_nib_d  = load_i ? data_i : stage_nib_q;
    stage_dp_d   = load_i ? dp_i   : stage_dp_q;
    shadow_nib_d = shadow_nib_q;
    shadow_dp_d  = shadow_dp_q;
    if (boundary && pending_q) begin
      shadow_nib_d = stage_nib_q;
      shadow_dp_d  = stage_dp_q;
    end
    if (load_i)        pending_d = 1'b1;
    else if (boundary) pending_d = 1'b0;
    else               pending_d = pending_q;
  end

  // Leading-zero suppression: digit i hides when it and every digit above are zero.
  always_comb begin
    zeros_above = 1'b1;
    supp        = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros_above = zeros_above && (shadow_nib_q[4*i +: 4] == 4'h0);
      supp[i]     = lz_supp_i && (i != 0) && zeros_above;
    end
  end

  assign cur_nib = nib_sel(32'(shadow_nib_q), 3'(idx_q));

  hex_7seg u_hex_7seg (
    .nib_i (cur_nib),
    .seg_o (dec)
  );

  assign visible = en_i[idx_q] && !supp[idx_q];

  // Next segment/anode pattern for the current slot phase.
  always_comb begin
    an_sel        = AN_OFF;
    an_sel[idx_q] = 1'b0;
    seg_d         = SEG_OFF;
    an_d          = AN_OFF;
    if (!in_blank && visible) begin
      an_d  = an_sel;
      seg_d = {~shadow_dp_q[idx_q], dec};
    end
  end

  // All state, including the registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      stage_nib_q  <= '0;
      stage_dp_q   <= '0;
      shadow_nib_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      ack_q        <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stage_nib_q  <= stage_nib_d;
      stage_dp_q   <= stage_dp_d;
      shadow_nib_q <= shadow_nib_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      ack_q        <= boundary && pending_q;
      tick_q       <= boundary;
    end
  end

  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign load_ack_o   = ack_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 8 clocks per slot, 2 blank clocks).
module tb_seg7_scan_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] data_i;
  logic [3:0]  dp_i, en_i;
  logic        lz_supp_i, load_i;
  logic        load_ack_o, frame_tick_o;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int cyc     = 0;
  int last_tick = 0;
  bit tick_valid = 1'b0;
  int a0;

  localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .dp_i(dp_i), .en_i(en_i),
    .lz_supp_i(lz_supp_i), .load_i(load_i), .load_ack_o(load_ack_o),
    .frame_tick_o(frame_tick_o), .seg_o(seg_o), .an_o(an_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Per-cycle monitor: anode one-hot, frame-tick period, ACK count.
  always @(posedge clk_i) begin
    #1;
    cyc++;
    check("an_onehot", 32'($countones(~an_o) <= 1), 32'd1);
    if (!rst_n_i) tick_valid = 1'b0;
    else if (frame_tick_o) begin
      if (tick_valid) check("tick_period", 32'(cyc - last_tick), 32'd32);
      last_tick  = cyc;
      tick_valid = 1'b1;
    end
    if (load_ack_o) ack_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_i = d; dp_i = p; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!frame_tick_o && n < 80);
    check("tick_seen", 32'(frame_tick_o), 32'd1);
  endtask

  // Called at the negedge right after a frame tick; checks blank and drive of every slot.
  task automatic check_frame(input logic [31:0] seg_exp, input logic [15:0] an_exp);
    int off = 0;
    for (int s = 0; s < 4; s++) begin
      while (off < 8*s + 1) begin step(1); off++; end
      check($sformatf("blank_seg%0d", s), 32'(seg_o), 32'hFF);
      check($sformatf("blank_an%0d", s), 32'(an_o), 32'hF);
      while (off < 8*s + 5) begin step(1); off++; end
      check($sformatf("drive_seg%0d", s), 32'(seg_o), 32'(seg_exp[8*s +: 8]));
      check($sformatf("drive_an%0d", s), 32'(an_o), 32'(an_exp[4*s +: 4]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst_n_i = 1'b0; data_i = '0; dp_i = '0; en_i = 4'hF; lz_supp_i = 1'b0; load_i = 1'b0;

    // 1: reset state and first slot timing
    step(3);
    check("rst_seg", 32'(seg_o), 32'hFF);
    check("rst_an", 32'(an_o), 32'hF);
    check("rst_ack", 32'(load_ack_o), 32'd0);
    check("rst_tick", 32'(frame_tick_o), 32'd0);
    rst_n_i = 1'b1;
    step(1); check("rel_an1", 32'(an_o), 32'hF); check("rel_seg1", 32'(seg_o), 32'hFF);
    step(1); check("rel_an2", 32'(an_o), 32'hF);
    step(1); check("rel_an3", 32'(an_o), 32'hE); check("rel_seg3", 32'(seg_o), 32'hC0);

    // 2: basic load, decode and DP
    do_load(16'h12A0, 4'b0100);
    wait_tick();
    check("ack_t2", 32'(load_ack_o), 32'd1);
    check_frame({8'hF9, 8'h24, 8'h88, 8'hC0}, AN_ALL);

    // 3: leading-zero suppression
    lz_supp_i = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_tick();
    check("ack_t3a", 32'(load_ack_o), 32'd1);
    check_frame({8'hFF, 8'hFF, 8'h92, 8'hC0}, {4'hF, 4'hF, 4'b1101, 4'b1110});
    do_load(16'h0000, 4'b0000);
    wait_tick();
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hC0}, {4'hF, 4'hF, 4'hF, 4'b1110});

    // 4: last write wins with one ACK; LOAD in the boundary cycle defers
    wait_tick();
    a0 = ack_cnt;
    do_load(16'h1111, 4'b0000);
    step(5);
    do_load(16'h2222, 4'b0000);
    wait_tick();
    check_frame({4{8'hA4}}, AN_ALL);
    check("ack_once", 32'(ack_cnt - a0), 32'd1);
    a0 = ack_cnt;
    do_load(16'h4444, 4'b0000);
    step(1);
    data_i = 16'h3333; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    check("bnd_tick", 32'(frame_tick_o), 32'd1);
    check("bnd_ack", 32'(load_ack_o), 32'd1);
    check_frame({4{8'h99}}, AN_ALL);
    wait_tick();
    check("late_ack", 32'(load_ack_o), 32'd1);
    check_frame({4{8'hB0}}, AN_ALL);
    check("ack_two", 32'(ack_cnt - a0), 32'd2);

    // 5: live digit enable
    en_i = 4'b1010; lz_supp_i = 1'b0;
    wait_tick();
    check_frame({8'hB0, 8'hFF, 8'hB0, 8'hFF}, {4'b0111, 4'hF, 4'b1101, 4'hF});

    // 6: async reset mid-DRIVE of digit 2 with a load pending
    en_i = 4'hF;
    wait_tick();
    step(21);
    do_load(16'h5555, 4'b1111);
    check("pre_rst_an", 32'(an_o), 32'b1011);
    rst_n_i = 1'b0;
    #1;
    check("async_seg", 32'(seg_o), 32'hFF);
    check("async_an", 32'(an_o), 32'hF);
    step(2);
    a0 = ack_cnt;
    rst_n_i = 1'b1;
    wait_tick();
    check("post_rst_ack", 32'(load_ack_o), 32'd0);
    check_frame({4{8'hC0}}, AN_ALL);
    check("post_rst_nack", 32'(ack_cnt - a0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
